// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//   Drain stage for the synchronous 8-bit FIFO. Pops one byte at a time
//   through the FIFO read port and serialises it as an 8N1 frame on txd
//   (start bit, 8 data bits LSB first, stop bit). Frame status is reported
//   through busy, byte_done and a wrapping frame counter.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (must be >= 2)
//   CNT_W         width of frame_cnt
//
// Ports
//   clk        in   1      system clock, all logic on posedge
//   rst        in   1      synchronous active-low reset
//   en         in   1      drain enable, looked at only while idle
//   fempty     in   1      FIFO empty flag
//   fifo_dout  in   8      FIFO read data, valid the cycle after rd
//   rd         out  1      FIFO read strobe, one-cycle pulse per byte
//   txd        out  1      serial output, idles high
//   busy       out  1      high whenever a byte is being fetched or sent
//   byte_done  out  1      one-cycle pulse after a stop bit completes
//   frame_cnt  out  CNT_W  completed frames, wraps modulo 2^CNT_W
//
// FIFO read handshake: the block decides to fetch only in IDLE, and only when
// en==1 and fempty==0 on that same edge. It then pulses rd for exactly one
// cycle (FETCH), lets the FIFO present the byte during the following cycle
// (CAPT) and latches fifo_dout at the end of CAPT. fempty and fifo_dout are
// ignored at every other time, so no underflow read can be issued and at
// most one byte is popped per frame.
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             fempty,
   input  logic [7:0]       fifo_dout,
   output logic             rd,
   output logic             txd,
   output logic             busy,
   output logic             byte_done,
   output logic [CNT_W-1:0] frame_cnt
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
         $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
      end
   endgenerate

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_CAPT  = 3'd2;
   localparam logic [2:0] S_START = 3'd3;
   localparam logic [2:0] S_DATA  = 3'd4;
   localparam logic [2:0] S_STOP  = 3'd5;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   // state is kept as a plain named register so checkers can bind to it
   logic [2:0]        state;
   logic [2:0]        bit_idx;
   logic [BAUD_W-1:0] baud;
   logic [7:0]        shreg;

   logic baud_last;
   assign baud_last = (baud == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         bit_idx   <= 3'd0;
         baud      <= '0;
         shreg     <= 8'h00;
         txd       <= 1'b1;
         rd        <= 1'b0;
         busy      <= 1'b0;
         byte_done <= 1'b0;
         frame_cnt <= '0;
      end else begin
         // pulse outputs default low; the transitions below raise them
         rd        <= 1'b0;
         byte_done <= 1'b0;

         case (state)
            S_IDLE: begin
               txd     <= 1'b1;
               baud    <= '0;
               bit_idx <= 3'd0;
               if (en && !fempty) begin
                  state <= S_FETCH;
                  rd    <= 1'b1;   // registered, so rd is high during FETCH
                  busy  <= 1'b1;
               end
            end

            S_FETCH: begin
               state <= S_CAPT;
            end

            S_CAPT: begin
               // the FIFO presents the popped byte during this cycle
               shreg <= fifo_dout;
               state <= S_START;
               txd   <= 1'b0;
               baud  <= '0;
            end

            S_START: begin
               if (baud_last) begin
                  baud    <= '0;
                  bit_idx <= 3'd0;
                  state   <= S_DATA;
                  txd     <= shreg[0];
               end else begin
                  baud <= baud + BAUD_W'(1);
               end
            end

            S_DATA: begin
               if (baud_last) begin
                  baud  <= '0;
                  shreg <= {1'b0, shreg[7:1]};
                  if (bit_idx == 3'd7) begin
                     state <= S_STOP;
                     txd   <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     // next bit is what becomes shreg[0] after this shift
                     txd     <= shreg[1];
                  end
               end else begin
                  baud <= baud + BAUD_W'(1);
               end
            end

            S_STOP: begin
               txd <= 1'b1;
               if (baud_last) begin
                  baud      <= '0;
                  state     <= S_IDLE;
                  busy      <= 1'b0;
                  byte_done <= 1'b1;
                  frame_cnt <= frame_cnt + CNT_W'(1);
               end else begin
                  baud <= baud + BAUD_W'(1);
               end
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               txd   <= 1'b1;
               baud  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Directed sequence with random payload bytes for fifo_uart_tx.
//   dut   : CLKS_PER_BIT=4, CNT_W=16, fed by a behavioural FIFO
//   dut2  : CLKS_PER_BIT=4, CNT_W=2, shares dut's inputs (counter wrap)
//   dut3  : CLKS_PER_BIT=2, own inputs, single 0x55 frame
//   Expected frames come from exp_q (bytes in push order); the expected txd
//   level at each cycle is derived from the frame layout arithmetically.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

   localparam int C  = 4;
   localparam int FL = 2 + 10 * C;   // samples from rd to byte_done

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en  = 1'b0;
   logic        fempty;
   logic [7:0]  fifo_dout = 8'h00;
   logic        rd, txd, busy, byte_done;
   logic [15:0] frame_cnt;

   logic        rd2, txd2, busy2, byte_done2;
   logic [1:0]  frame_cnt2;

   logic        en3 = 1'b0;
   logic        fempty3 = 1'b1;
   logic [7:0]  fifo_dout3 = 8'h55;
   logic        rd3, txd3, busy3, byte_done3;
   logic [15:0] frame_cnt3;

   // behavioural FIFO: initial block owns wr_ptr, the read process owns rd_ptr
   logic [7:0]  mem [0:255];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   assign fempty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (rd === 1'b1) begin
         fifo_dout <= mem[rd_ptr[7:0]];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   logic [7:0] exp_q [$];
   int         exp_cnt = 0;
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   fifo_uart_tx #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .en(en), .fempty(fempty), .fifo_dout(fifo_dout),
      .rd(rd), .txd(txd), .busy(busy), .byte_done(byte_done), .frame_cnt(frame_cnt)
   );

   fifo_uart_tx #(.CLKS_PER_BIT(C), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .fempty(fempty), .fifo_dout(fifo_dout),
      .rd(rd2), .txd(txd2), .busy(busy2), .byte_done(byte_done2), .frame_cnt(frame_cnt2)
   );

   fifo_uart_tx #(.CLKS_PER_BIT(2), .CNT_W(16)) dut3 (
      .clk(clk), .rst(rst), .en(en3), .fempty(fempty3), .fifo_dout(fifo_dout3),
      .rd(rd3), .txd(txd3), .busy(busy3), .byte_done(byte_done3), .frame_cnt(frame_cnt3)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no end of sequence, required $finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // line level of an 8N1 frame k samples after the rd sample
   function automatic logic exp_txd(input logic [7:0] b, input int k, input int c);
      int p;
      if (k < 2) return 1'b1;
      p = (k - 2) / c;
      if (p == 0) return 1'b0;
      if (p <= 8) return b[p-1];
      return 1'b1;
   endfunction

   task automatic push_byte(input logic [7:0] b);
      mem[wr_ptr[7:0]] = b;
      wr_ptr++;
      exp_q.push_back(b);
   endtask

   task automatic wait_rd(input string tag, input int bound, output int n);
      n = 0;
      while (rd !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      chk({tag, "_rd"}, {31'd0, rd}, 32'd1);
      chk({tag, "_rd2"}, {31'd0, rd2}, 32'd1);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
   endtask

   // called at the sample where rd is high; follows the frame to byte_done
   task automatic check_frame(input string tag, input int en_drop_k, input int abort_k);
      logic [7:0] b;
      if (exp_q.size() == 0) begin
         chk({tag, "_expq_empty"}, 32'd0, 32'd1);
         return;
      end
      b = exp_q.pop_front();
      for (int k = 1; k <= FL; k++) begin
         tick();
         if (k == en_drop_k) en = 1'b0;
         if (k == abort_k) begin
            rst = 1'b0;
            tick();
            rst = 1'b1;
            exp_cnt = 0;
            chk({tag, "_abort_txd"}, {31'd0, txd}, 32'd1);
            chk({tag, "_abort_busy"}, {31'd0, busy}, 32'd0);
            chk({tag, "_abort_done"}, {31'd0, byte_done}, 32'd0);
            chk({tag, "_abort_cnt"}, {16'd0, frame_cnt}, 32'd0);
            return;
         end
         chk($sformatf("%s_txd_k%0d", tag, k), {31'd0, txd}, {31'd0, exp_txd(b, k, C)});
         chk($sformatf("%s_txd2_k%0d", tag, k), {31'd0, txd2}, {31'd0, exp_txd(b, k, C)});
         chk($sformatf("%s_rd_k%0d", tag, k), {31'd0, rd}, 32'd0);
         chk($sformatf("%s_busy_k%0d", tag, k), {31'd0, busy}, (k < FL) ? 32'd1 : 32'd0);
         chk($sformatf("%s_done_k%0d", tag, k), {31'd0, byte_done}, (k == FL) ? 32'd1 : 32'd0);
         if (k == FL) begin
            exp_cnt++;
            chk({tag, "_cnt"}, {16'd0, frame_cnt}, exp_cnt & 32'hFFFF);
            chk({tag, "_cnt2"}, {30'd0, frame_cnt2}, exp_cnt & 32'h3);
            chk({tag, "_done2"}, {31'd0, byte_done2}, 32'd1);
            chk({tag, "_busy2"}, {31'd0, busy2}, 32'd0);
         end
      end
   endtask

   initial begin
      int n;
      logic [7:0] b;

      // reset
      rst = 1'b0;
      repeat (3) tick();
      chk("rst_txd", {31'd0, txd}, 32'd1);
      chk("rst_rd", {31'd0, rd}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, byte_done}, 32'd0);
      chk("rst_cnt", {16'd0, frame_cnt}, 32'd0);
      chk("rst_txd3", {31'd0, txd3}, 32'd1);
      rst = 1'b1;
      tick();

      // 1: single 0xA5 frame
      push_byte(8'hA5);
      en = 1'b1;
      wait_rd("t1", 5, n);
      chk("t1_latency", n, 32'd1);
      check_frame("t1", 0, 0);

      // 2: three preloaded bytes sent back to back
      en = 1'b0;
      push_byte(8'h00);
      push_byte(8'hFF);
      push_byte(8'h3C);
      en = 1'b1;
      wait_rd("t2a", 5, n);
      check_frame("t2a", 0, 0);
      wait_rd("t2b", 5, n);
      chk("t2b_spacing", n, 32'd1);
      check_frame("t2b", 0, 0);
      wait_rd("t2c", 5, n);
      chk("t2c_spacing", n, 32'd1);
      check_frame("t2c", 0, 0);

      // 3: enabled but empty FIFO, then one random byte arrives
      for (int i = 0; i < 100; i++) begin
         tick();
         chk("t3_idle_rd", {31'd0, rd}, 32'd0);
         chk("t3_idle_txd", {31'd0, txd}, 32'd1);
         chk("t3_idle_busy", {31'd0, busy}, 32'd0);
      end
      push_byte(8'($urandom));
      chk("t3_rd_before", {31'd0, rd}, 32'd0);
      tick();
      chk("t3_rd_after", {31'd0, rd}, 32'd1);
      check_frame("t3", 0, 0);

      // 4: en dropped during data bit 3 of 0x81, FIFO still non-empty
      push_byte(8'h81);
      push_byte(8'($urandom));
      wait_rd("t4a", 5, n);
      check_frame("t4a", 2 + C + 3 * C + 1, 0);
      for (int i = 0; i < 30; i++) begin
         tick();
         chk("t4_hold_rd", {31'd0, rd}, 32'd0);
         chk("t4_hold_busy", {31'd0, busy}, 32'd0);
      end
      en = 1'b1;
      wait_rd("t4b", 5, n);
      chk("t4b_latency", n, 32'd1);
      check_frame("t4b", 0, 0);

      // 5: reset pulse during data bit 5; restart sends the following byte
      push_byte(8'($urandom));
      push_byte(8'($urandom));
      wait_rd("t5a", 5, n);
      check_frame("t5a", 0, 2 + C + 5 * C + 1);
      wait_rd("t5b", 5, n);
      chk("t5b_latency", n, 32'd1);
      check_frame("t5b", 0, 0);

      // 6: five frames with random gaps; dut2's 2-bit counter wraps
      rst = 1'b0;
      tick();
      rst = 1'b1;
      exp_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         repeat ($urandom_range(0, 8)) begin
            tick();
            chk("t6_gap_busy", {31'd0, busy}, 32'd0);
         end
         push_byte(8'($urandom));
         wait_rd("t6", 5, n);
         chk("t6_latency", n, 32'd1);
         check_frame("t6", 0, 0);
      end

      // 6b: CLKS_PER_BIT=2 instance sends 0x55
      b = fifo_dout3;
      fempty3 = 1'b0;
      en3 = 1'b1;
      n = 0;
      while (rd3 !== 1'b1 && n < 5) begin
         tick();
         n++;
      end
      chk("t6b_rd", {31'd0, rd3}, 32'd1);
      fempty3 = 1'b1;
      for (int k = 1; k <= 2 + 10 * 2; k++) begin
         tick();
         chk($sformatf("t6b_txd_k%0d", k), {31'd0, txd3}, {31'd0, exp_txd(b, k, 2)});
         chk($sformatf("t6b_busy_k%0d", k), {31'd0, busy3}, (k < 22) ? 32'd1 : 32'd0);
         chk($sformatf("t6b_done_k%0d", k), {31'd0, byte_done3}, (k == 22) ? 32'd1 : 32'd0);
      end
      chk("t6b_cnt", {16'd0, frame_cnt3}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t6b_no_rd", {31'd0, rd3}, 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
